// File: rtl/softctl_frame_latch.sv
// Frame-synchronous latch for the NIOS soft-control word: samples continuously,
// commits to draw_engine only at vblank start (or on a missing-vblank timeout).
module softctl_frame_latch #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned STALL_BITS = 21
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] softctl_in,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  spine_x_in,
    output logic [1:0]  bg_index,
    output logic [2:0]  mario_index,
    output logic [2:0]  level_index,
    output logic [9:0]  mario_pos_x,
    output logic [9:0]  mario_pos_y,
    output logic        is_death,
    output logic        trigger,
    output logic        reset_game,
    output logic        trigger_pulse,
    output logic        frame_start,
    output logic        vga_stall,
    output logic [31:0] position_out
);

    localparam logic [9:0] VblankLine = 10'(V_VISIBLE);
    localparam logic [9:0] XMax       = 10'(H_VISIBLE - 1);
    localparam logic [9:0] YMax       = 10'(V_VISIBLE - 1);
    localparam logic [STALL_BITS-1:0] StallMax = '1;
    localparam logic [STALL_BITS-1:0] StallOne = {{(STALL_BITS-1){1'b0}}, 1'b1};

    logic [31:0]           shadow_q, shadow_d;
    logic [31:0]           active_q, active_d;
    logic [9:0]            dy_q, dy_d;
    logic [9:0]            spine_q, spine_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [STALL_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic                  vga_stall_q, vga_stall_d;
    logic                  init_pending_q, init_pending_d;
    logic                  frame_start_q, frame_start_d;
    logic                  trigger_pulse_q, trigger_pulse_d;

    logic genuine_commit;
    logic stall_saturated;
    logic commit;
    logic reset_game_w;

    always_comb begin
        genuine_commit  = (DrawY == VblankLine) && (dy_q != VblankLine);
        stall_saturated = (stall_cnt_q == StallMax);
        commit          = genuine_commit || stall_saturated;

        shadow_d        = softctl_in;
        dy_d            = DrawY;
        active_d        = active_q;
        spine_d         = spine_q;
        frame_cnt_d     = frame_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        vga_stall_d     = vga_stall_q;
        init_pending_d  = init_pending_q;
        frame_start_d   = commit;
        // Edge is judged against the currently visible trigger, not the raw PIO bit.
        trigger_pulse_d = commit && shadow_q[21] && !active_q[21];

        if (commit) begin
            active_d       = shadow_q;
            spine_d        = spine_x_in;
            frame_cnt_d    = shadow_q[22] ? 16'd0 : frame_cnt_q + 16'd1;
            init_pending_d = 1'b0;
        end

        // A real vblank always wins over a coincident timeout.
        if (genuine_commit) begin
            stall_cnt_d = '0;
            vga_stall_d = 1'b0;
        end else if (stall_saturated) begin
            stall_cnt_d = '0;
            vga_stall_d = 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q + StallOne;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_q        <= '0;
            active_q        <= '0;
            dy_q            <= '0;
            spine_q         <= '0;
            frame_cnt_q     <= '0;
            stall_cnt_q     <= '0;
            vga_stall_q     <= 1'b0;
            init_pending_q  <= 1'b1;
            frame_start_q   <= 1'b0;
            trigger_pulse_q <= 1'b0;
        end else begin
            shadow_q        <= shadow_d;
            active_q        <= active_d;
            dy_q            <= dy_d;
            spine_q         <= spine_d;
            frame_cnt_q     <= frame_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            vga_stall_q     <= vga_stall_d;
            init_pending_q  <= init_pending_d;
            frame_start_q   <= frame_start_d;
            trigger_pulse_q <= trigger_pulse_d;
        end
    end

    // Outputs derive only from registered state through clamp/AND logic.
    always_comb begin
        reset_game_w  = active_q[22] || init_pending_q;
        bg_index      = active_q[31:30];
        mario_index   = active_q[29:27];
        level_index   = active_q[26:24];
        mario_pos_x   = (active_q[19:10] > XMax) ? XMax : active_q[19:10];
        mario_pos_y   = (active_q[9:0] > YMax) ? YMax : active_q[9:0];
        reset_game    = reset_game_w;
        is_death      = active_q[20] && !reset_game_w;
        trigger       = active_q[21];
        trigger_pulse = trigger_pulse_q;
        frame_start   = frame_start_q;
        vga_stall     = vga_stall_q;
        position_out  = {frame_cnt_q, 5'd0, vga_stall_q, spine_q};
    end

endmodule

// File: tb/tb_softctl_frame_latch.sv
// Directed and randomized checks of softctl_frame_latch against a per-cycle
// reference model built from the commit/clamp/counter rules.
module tb_softctl_frame_latch;

    localparam int unsigned SB         = 6;   // short timeout so the stall case fits the run
    localparam int unsigned StallLimit = (1 << SB) - 1;
    localparam int unsigned HVis       = 640;
    localparam int unsigned VVis       = 480;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] softctl_in = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  spine_x_in = '0;
    logic [1:0]  bg_index;
    logic [2:0]  mario_index;
    logic [2:0]  level_index;
    logic [9:0]  mario_pos_x;
    logic [9:0]  mario_pos_y;
    logic        is_death;
    logic        trigger;
    logic        reset_game;
    logic        trigger_pulse;
    logic        frame_start;
    logic        vga_stall;
    logic [31:0] position_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_shadow, m_active;
    logic [9:0]  m_dy, m_spine;
    int unsigned m_fcnt, m_cnt;
    bit          m_init, m_stall, m_fs, m_tp;

    softctl_frame_latch #(
        .H_VISIBLE (HVis),
        .V_VISIBLE (VVis),
        .STALL_BITS(SB)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .softctl_in   (softctl_in),
        .DrawY        (DrawY),
        .spine_x_in   (spine_x_in),
        .bg_index     (bg_index),
        .mario_index  (mario_index),
        .level_index  (level_index),
        .mario_pos_x  (mario_pos_x),
        .mario_pos_y  (mario_pos_y),
        .is_death     (is_death),
        .trigger      (trigger),
        .reset_game   (reset_game),
        .trigger_pulse(trigger_pulse),
        .frame_start  (frame_start),
        .vga_stall    (vga_stall),
        .position_out (position_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_dy = '0; m_spine = '0;
        m_fcnt = 0; m_cnt = 0; m_init = 1; m_stall = 0; m_fs = 0; m_tp = 0;
    endtask

    task automatic model_clock(input logic [31:0] sc, input logic [9:0] dy, input logic [9:0] sp);
        bit genuine, timeout;
        genuine = (int'(dy) == VVis) && (int'(m_dy) != VVis);
        timeout = (m_cnt == StallLimit);
        m_fs = genuine || timeout;
        m_tp = 0;
        if (m_fs) begin
            m_tp     = m_shadow[21] && !m_active[21];
            m_active = m_shadow;
            m_spine  = sp;
            m_fcnt   = m_shadow[22] ? 0 : (m_fcnt + 1) % 65536;
            m_init   = 0;
        end
        if (genuine) begin
            m_cnt = 0; m_stall = 0;
        end else if (timeout) begin
            m_cnt = 0; m_stall = 1;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_shadow = sc;
        m_dy     = dy;
    endtask

    task automatic check_all();
        int ex, ey;
        bit rg;
        ex = int'(m_active[19:10]);
        ey = int'(m_active[9:0]);
        if (ex > HVis - 1) ex = HVis - 1;
        if (ey > VVis - 1) ey = VVis - 1;
        rg = m_active[22] || m_init;
        check("bg_index",      32'(bg_index),      32'(m_active[31:30]));
        check("mario_index",   32'(mario_index),   32'(m_active[29:27]));
        check("level_index",   32'(level_index),   32'(m_active[26:24]));
        check("mario_pos_x",   32'(mario_pos_x),   32'(ex));
        check("mario_pos_y",   32'(mario_pos_y),   32'(ey));
        check("reset_game",    32'(reset_game),    32'(rg));
        check("is_death",      32'(is_death),      32'(m_active[20] && !rg));
        check("trigger",       32'(trigger),       32'(m_active[21]));
        check("trigger_pulse", 32'(trigger_pulse), 32'(m_tp));
        check("frame_start",   32'(frame_start),   32'(m_fs));
        check("vga_stall",     32'(vga_stall),     32'(m_stall));
        check("position_out",  position_out, {16'(m_fcnt), 5'd0, m_stall, m_spine});
    endtask

    task automatic step(input logic [31:0] sc, input logic [9:0] dy, input logic [9:0] sp);
        softctl_in = sc;
        DrawY      = dy;
        spine_x_in = sp;
        @(posedge Clk);
        model_clock(sc, dy, sp);
        #1;
        check_all();
    endtask

    task automatic commit_word(input logic [31:0] sc, input logic [9:0] sp);
        step(sc, 10'd479, sp);
        step(sc, 10'd480, sp);
    endtask

    // Asynchronous reset mid-cycle, held across one edge, released mid-cycle.
    task automatic apply_reset();
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_reset_game", 32'(reset_game), 32'd1);
        check("rst_position", position_out, 32'd0);
        @(posedge Clk);
        #1;
        check_all();
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [9:0]  cur_dy;
        int          n;

        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        Reset_n = 1'b1;

        // Stays in init until the first commit
        repeat (3) step(32'd0, 10'd200, 10'd0);
        check("init_reset_game", 32'(reset_game), 32'd1);
        commit_word(32'd0, 10'd0);
        check("first_commit_reset_game", 32'(reset_game), 32'd0);

        // Tear-free commit
        w = 32'h4A0C_8064;
        repeat (4) step(w, 10'd200, 10'd0);
        check("pre_commit_bg", 32'(bg_index), 32'd0);
        commit_word(w, 10'd0);
        check("commit_bg",    32'(bg_index),    32'd1);
        check("commit_mario", 32'(mario_index), 32'd1);
        check("commit_level", 32'(level_index), 32'd2);
        check("commit_x",     32'(mario_pos_x), 32'd639);
        check("commit_y",     32'(mario_pos_y), 32'h064);
        check("commit_fs",    32'(frame_start), 32'd1);
        step(w, 10'd480, 10'd0);
        check("held_vblank_fs", 32'(frame_start), 32'd0);

        // Clamp boundaries
        commit_word((32'd700 << 10) | 32'd500, 10'd0);
        check("clamp_x", 32'(mario_pos_x), 32'd639);
        check("clamp_y", 32'(mario_pos_y), 32'd479);
        commit_word((32'd639 << 10) | 32'd479, 10'd0);
        check("edge_x", 32'(mario_pos_x), 32'd639);
        check("edge_y", 32'(mario_pos_y), 32'd479);

        // Trigger edge detect over commits 0,1,1
        commit_word(32'd0, 10'd0);
        check("trig0_pulse", 32'(trigger_pulse), 32'd0);
        commit_word(32'd1 << 21, 10'd0);
        check("trig1_pulse", 32'(trigger_pulse), 32'd1);
        step(32'd1 << 21, 10'd479, 10'd0);
        check("trig1_pulse_width", 32'(trigger_pulse), 32'd0);
        step(32'd1 << 21, 10'd480, 10'd0);
        check("trig2_pulse", 32'(trigger_pulse), 32'd0);
        check("trig2_level", 32'(trigger), 32'd1);

        // Death masked by reset_game
        commit_word((32'd1 << 22) | (32'd1 << 20), 10'd0);
        check("death_masked", 32'(is_death), 32'd0);
        check("death_rg", 32'(reset_game), 32'd1);
        commit_word(32'd1 << 20, 10'd0);
        check("death_live", 32'(is_death), 32'd1);

        // Reset in the middle of a commit cycle, then frame counter
        step(32'hFFFF_FFFF, 10'd479, 10'h3FF);
        softctl_in = 32'hFFFF_FFFF;
        DrawY      = 10'd480;
        apply_reset();
        repeat (3) commit_word(32'd0, 10'h123);
        check("frame_cnt_3", position_out, 32'h0003_0123);
        commit_word(32'd1 << 22, 10'h123);
        check("frame_cnt_clear", 32'(position_out[31:16]), 32'd0);

        // Missing vblank: forced commit after 2^SB cycles
        commit_word(32'd0, 10'h055);
        n = 0;
        for (int i = 1; i <= 4 * (1 << SB) && n == 0; i++) begin
            step(32'd0, 10'd100, 10'h055);
            if (frame_start === 1'b1) n = i;
        end
        check("stall_period", 32'(n), 32'(1 << SB));
        check("stall_flag", 32'(vga_stall), 32'd1);
        check("stall_pos_bit", 32'(position_out[10]), 32'd1);
        commit_word(32'd0, 10'h055);
        check("stall_cleared", 32'(vga_stall), 32'd0);

        // Genuine commit coinciding with counter saturation
        repeat (StallLimit) step(32'd0, 10'd479, 10'd0);
        step(32'd0, 10'd480, 10'd0);
        check("coincide_fs", 32'(frame_start), 32'd1);
        check("coincide_stall", 32'(vga_stall), 32'd0);

        // Randomized traffic
        cur_dy = 10'd0;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0:       cur_dy = 10'd479;
                1:       cur_dy = 10'd480;
                2:       cur_dy = 10'($urandom_range(0, 1023));
                default: ;
            endcase
            step($urandom, cur_dy, 10'($urandom_range(0, 1023)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
